note_lane_scheduler: RTL and testbench
======================================

Name: note_lane_scheduler

Overview:
- Sequences the falling-note playfield for the 4-lane display.
- Walks the song pattern ROM one entry per beat_tick and spawns notes into a fixed per-lane slot pool.
- Advances every live note once per frame_tick and retires notes that leave the screen.
- Judges key presses against the hit bar; the renderer draws directly from the exported note_valid/note_y vectors.

Parameters:
- NUM_SLOTS, 4, note slots per lane (4 lanes fixed).
- Y_WIDTH, 10, width of each note y coordinate (unsigned, top edge).
- SCREEN_HEIGHT, 480, y at or beyond which a note is retired.
- NOTE_HEIGHT, 50, note height in pixels.
- HIT_Y, 350, hit bar top y.
- HIT_H, 20, hit bar height.
- SPAWN_Y, 0, initial y of a spawned note.
- SPEED, 1, pixels added per frame_tick.
- SONG_LEN, 63, number of pattern entries.
- ADDR_WIDTH, 6, pattern ROM address width.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a song from entry 0
- frame_tick  in  1  one-cycle pulse per video frame
- beat_tick  in  1  one-cycle pulse per pattern entry
- key  in  4  debounced lane keys, level; bit 3 = lane 0 (leftmost)
- pat_addr  out  ADDR_WIDTH  pattern ROM address
- pat_data  in  4  ROM data, valid 1 cycle after pat_addr; bit 3 = lane 0
- note_valid  out  4*NUM_SLOTS  slot live flags, index lane*NUM_SLOTS+slot
- note_y  out  4*NUM_SLOTS*Y_WIDTH  slot y, same indexing
- hit_pulse  out  4  one-cycle, per lane, note hit
- miss_pulse  out  4  one-cycle, per lane, note missed
- dropped  out  4  one-cycle, per lane, spawn lost (pool full)
- hit_count  out  16  saturating hit total
- busy  out  1  high from start until DONE
- song_done  out  1  high in DONE

Behaviour:
- Reset (async assert, sync release) clears everything:
  - all note_valid=0, note_y=0
  - all pulses 0, hit_count=0, pat_addr=0
  - busy=0, song_done=0, key history=0, state IDLE
- Reset mid-song discards all notes with no miss pulses.
- States:
  - IDLE: start -> RUN, pat_addr=0, busy=1.
  - RUN: beat_tick -> FETCH.
  - FETCH: 1 wait cycle for ROM latency -> SPAWN.
  - SPAWN: for each lane bit set in pat_data, allocate the lowest-index invalid slot (valid=1, y=SPAWN_Y). If the lane has no free slot, pulse dropped[lane] and do not allocate. Then: if pat_addr==SONG_LEN-1 -> DRAIN, else pat_addr+1 -> RUN.
  - DRAIN: no spawns; when all note_valid==0 -> DONE.
  - DONE: song_done=1, busy=0; start -> RUN as from IDLE with cleared hit_count.
- Ignored inputs:
  - beat_tick outside RUN is ignored (not queued).
  - start while busy is ignored.
- Movement applies in RUN/FETCH/SPAWN/DRAIN, not in IDLE/DONE:
  - On frame_tick, every valid slot gets y <= y+SPEED, computed at Y_WIDTH+1 bits.
  - If the sum >= SCREEN_HEIGHT, the slot is invalidated and miss_pulse[lane] fires.
  - Multiple misses in one lane on the same cycle produce a single pulse.
- Spawn vs move on the same cycle: existing slots move; the newly spawned slot holds SPAWN_Y.
- Judging:
  - A key rising edge (key & ~key_q) in lane L, in any non-IDLE state, selects the lowest-index valid slot in L where y < HIT_Y+HIT_H and y+NOTE_HEIGHT > HIT_Y.
  - The selected slot is invalidated, hit_pulse[L] fires, and hit_count increments (saturating at 16'hFFFF).
  - Judging uses pre-move y.
  - A judged slot is neither moved nor retired that cycle; the hit wins and no miss fires.
  - If no slot overlaps: no pulse (see option).
- Outputs are registered and update the cycle after the triggering event.

Optional Feature:
- STRICT_PRESS_EN
  - Defined: a key rising edge in a non-IDLE state with no overlapping note pulses miss_pulse[L], OR-combined with any retire miss on the same cycle.
  - Undefined: such presses are silently ignored.

Test Plan:
- reset low mid-song with 3 live notes -> next cycle note_valid=0, busy=0, no pulses; after release, state IDLE.
- start, beat_tick with pat_data=4'b1000 -> 2 cycles later lane 0 slot 0 valid, y=0; 350 frame_ticks -> y=350.
- Lane 0 note at y=340, key[3] 0->1 -> hit_pulse=4'b1000, slot invalid, hit_count=1; hold key 5 cycles -> no further hits.
- Note at y=479 plus frame_tick -> slot invalid, miss_pulse for that lane; same cycle with key press while y in hit window (y=340) -> hit only, no miss.
- NUM_SLOTS=4, five beat_ticks of 4'b0001 with no frame_ticks -> slots 0-3 of lane 3 valid, fifth beat gives dropped=4'b0001.
- SONG_LEN=2, two beats then frames until all notes retire -> DRAIN then song_done=1, busy=0; start -> pat_addr=0, hit_count=0.

Source files
------------

// File: rtl/note_lane_scheduler.sv
// Falling-note playfield sequencer for a 4-lane display: spawns notes from a pattern ROM,
// moves/retires them per frame and judges key presses. Optional macro: STRICT_PRESS_EN.
module note_lane_scheduler #(
  parameter int NUM_SLOTS     = 4,
  parameter int Y_WIDTH       = 10,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NOTE_HEIGHT   = 50,
  parameter int HIT_Y         = 350,
  parameter int HIT_H         = 20,
  parameter int SPAWN_Y       = 0,
  parameter int SPEED         = 1,
  parameter int SONG_LEN      = 63,
  parameter int ADDR_WIDTH    = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             frame_tick,
  input  logic                             beat_tick,
  input  logic [3:0]                       key,
  output logic [ADDR_WIDTH-1:0]            pat_addr,
  input  logic [3:0]                       pat_data,
  output logic [4*NUM_SLOTS-1:0]           note_valid,
  output logic [4*NUM_SLOTS*Y_WIDTH-1:0]   note_y,
  output logic [3:0]                       hit_pulse,
  output logic [3:0]                       miss_pulse,
  output logic [3:0]                       dropped,
  output logic [15:0]                      hit_count,
  output logic                             busy,
  output logic                             song_done,
  output logic [2:0]                       dbg_state
);

  localparam int NS  = 4 * NUM_SLOTS;
  localparam int YW1 = Y_WIDTH + 1;
  localparam logic [YW1-1:0] SCR_LIM = YW1'(SCREEN_HEIGHT);
  localparam logic [YW1-1:0] WIN_HI  = YW1'(HIT_Y + HIT_H);
  localparam logic [YW1-1:0] WIN_LO  = YW1'(HIT_Y);
  localparam logic [YW1-1:0] NOTE_H  = YW1'(NOTE_HEIGHT);
  localparam logic [YW1-1:0] SPD     = YW1'(SPEED);
  localparam logic [Y_WIDTH-1:0] Y_SPAWN = Y_WIDTH'(SPAWN_Y);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SONG_LEN - 1);
`ifdef STRICT_PRESS_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FETCH = 3'd2,
    S_SPAWN = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   move_en, judge_en, spawn_en, start_acc;

  logic [NS-1:0]              valid_q, valid_d;
  logic [NS-1:0][Y_WIDTH-1:0] y_q, y_d;
  logic [3:0]                 key_q;
  logic [3:0]                 hit_q, hit_d, miss_q, miss_d, drop_q, drop_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;

  logic [3:0]    rise;
  logic [NS-1:0] in_win;
  logic [NS-1:0] judged;
  logic          found, free_found;
  logic [2:0]    nhits;
  logic [YW1-1:0] sum;
  logic [16:0]   cnt_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (beat_tick) state_d = S_FETCH;
      S_FETCH: state_d = S_SPAWN;
      S_SPAWN: state_d = (addr_q == LAST_ADDR) ? S_DRAIN : S_RUN;
      S_DRAIN: if (valid_q == '0) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    move_en   = (state_q == S_RUN) || (state_q == S_FETCH) ||
                (state_q == S_SPAWN) || (state_q == S_DRAIN);
    judge_en  = (state_q != S_IDLE);
    spawn_en  = (state_q == S_SPAWN);
    start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    busy      = move_en;
    song_done = (state_q == S_DONE);
    dbg_state = state_q;
  end

  assign rise = key & ~key_q;

  // Hit window test on pre-move y; sums are one bit wider so they cannot wrap.
  for (genvar i = 0; i < NS; i++) begin : g_win
    assign in_win[i] = ({1'b0, y_q[i]} < WIN_HI) && (({1'b0, y_q[i]} + NOTE_H) > WIN_LO);
  end

  always_comb begin
    valid_d    = valid_q;
    y_d        = y_q;
    hit_d      = '0;
    miss_d     = '0;
    drop_d     = '0;
    judged     = '0;
    found      = 1'b0;
    free_found = 1'b0;
    sum        = '0;
    addr_d     = addr_q;

    for (int l = 0; l < 4; l++) begin
      found = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (!found && valid_q[l*NUM_SLOTS+s] && in_win[l*NUM_SLOTS+s]) begin
          found = 1'b1;
          if (judge_en && rise[3-l]) begin
            valid_d[l*NUM_SLOTS+s] = 1'b0;
            judged[l*NUM_SLOTS+s]  = 1'b1;
            hit_d[3-l]             = 1'b1;
          end
        end
      end
      if (STRICT && judge_en && rise[3-l] && !found) miss_d[3-l] = 1'b1;
    end

    // A judged slot neither moves nor retires this cycle.
    for (int i = 0; i < NS; i++) begin
      if (move_en && frame_tick && valid_q[i] && !judged[i]) begin
        sum = {1'b0, y_q[i]} + SPD;
        if (sum >= SCR_LIM) begin
          valid_d[i]             = 1'b0;
          miss_d[3 - i/NUM_SLOTS] = 1'b1;
        end else begin
          y_d[i] = sum[Y_WIDTH-1:0];
        end
      end
    end

    // Allocation looks at pre-cycle flags, so a spawned slot is never also moved.
    for (int l = 0; l < 4; l++) begin
      if (spawn_en && pat_data[3-l]) begin
        free_found = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (!free_found && !valid_q[l*NUM_SLOTS+s]) begin
            free_found             = 1'b1;
            valid_d[l*NUM_SLOTS+s] = 1'b1;
            y_d[l*NUM_SLOTS+s]     = Y_SPAWN;
          end
        end
        if (!free_found) drop_d[3-l] = 1'b1;
      end
    end

    if (start_acc) addr_d = '0;
    else if (spawn_en && (addr_q != LAST_ADDR)) addr_d = addr_q + 1'b1;
  end

  always_comb begin
    nhits   = 3'(hit_d[0]) + 3'(hit_d[1]) + 3'(hit_d[2]) + 3'(hit_d[3]);
    cnt_sum = {1'b0, cnt_q} + 17'(nhits);
    if (start_acc)        cnt_d = '0;
    else if (cnt_sum[16]) cnt_d = 16'hFFFF;
    else                  cnt_d = cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      y_q     <= '0;
      key_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      key_q   <= key;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign pat_addr   = addr_q;
  assign note_valid = valid_q;
  assign note_y     = y_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign dropped    = drop_q;
  assign hit_count  = cnt_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Directed bench for note_lane_scheduler: default instance plus a SONG_LEN=2 instance.
module tb_note_lane_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // Instance A: default parameters
  logic        start_a = 0, frame_a = 0, beat_a = 0;
  logic [3:0]  key_a = 0, pat_a = 0;
  logic [5:0]  addr_a;
  logic [15:0] valid_a;
  logic [159:0] y_a;
  logic [3:0]  hit_a, miss_a, drop_a;
  logic [15:0] cnt_a;
  logic        busy_a, done_a;
  logic [2:0]  st_a;

  // Instance B: two-entry song
  logic        start_b = 0, frame_b = 0, beat_b = 0;
  logic [3:0]  key_b = 0, pat_b = 0;
  logic [5:0]  addr_b;
  logic [15:0] valid_b;
  logic [159:0] y_b;
  logic [3:0]  hit_b, miss_b, drop_b;
  logic [15:0] cnt_b;
  logic        busy_b, done_b;
  logic [2:0]  st_b;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  note_lane_scheduler u_a (
    .clk(clk), .reset(reset), .start(start_a), .frame_tick(frame_a), .beat_tick(beat_a),
    .key(key_a), .pat_addr(addr_a), .pat_data(pat_a), .note_valid(valid_a), .note_y(y_a),
    .hit_pulse(hit_a), .miss_pulse(miss_a), .dropped(drop_a), .hit_count(cnt_a),
    .busy(busy_a), .song_done(done_a), .dbg_state(st_a)
  );

  note_lane_scheduler #(.SONG_LEN(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .frame_tick(frame_b), .beat_tick(beat_b),
    .key(key_b), .pat_addr(addr_b), .pat_data(pat_b), .note_valid(valid_b), .note_y(y_b),
    .hit_pulse(hit_b), .miss_pulse(miss_b), .dropped(drop_b), .hit_count(cnt_b),
    .busy(busy_b), .song_done(done_b), .dbg_state(st_b)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic beat(input bit sel_b, input logic [3:0] p);
    if (sel_b) begin pat_b = p; beat_b = 1; end else begin pat_a = p; beat_a = 1; end
    tick();
    beat_a = 0; beat_b = 0;
    tick();
    tick();
    pat_a = 0; pat_b = 0;
  endtask

  task automatic frames(input bit sel_b, input int n);
    if (sel_b) frame_b = 1; else frame_a = 1;
    for (int i = 0; i < n; i++) tick();
    frame_a = 0; frame_b = 0;
  endtask

  function automatic logic [9:0] yof(input logic [159:0] v, input int idx);
    return v[idx*10 +: 10];
  endfunction

  initial begin
    logic [3:0] strict_miss;
`ifdef STRICT_PRESS_EN
    strict_miss = 4'b0100;
`else
    strict_miss = 4'b0000;
`endif

    // Reset state
    tick(); tick();
    push(32'h0); chk("rst_valid", {16'h0, valid_a});
    push(32'h0); chk("rst_cnt", {16'h0, cnt_a});
    push(32'h0); chk("rst_addr", {26'h0, addr_a});
    push(32'h0); chk("rst_busy_done", {30'h0, busy_a, done_a});
    push(32'h0); chk("rst_state", {29'h0, st_a});
    reset = 1;
    tick();

    // Start and first spawn
    start_a = 1; tick(); start_a = 0;
    push(32'h1); chk("start_busy", {31'h0, busy_a});
    push(32'h1); chk("start_state_run", {29'h0, st_a});
    beat(0, 4'b1000);
    push(32'h0001); chk("spawn_valid", {16'h0, valid_a});
    push(32'd0);    chk("spawn_y", {22'h0, yof(y_a, 0)});
    push(32'd1);    chk("spawn_addr", {26'h0, addr_a});

    // Movement and hit
    frames(0, 340);
    push(32'd340); chk("move_340", {22'h0, yof(y_a, 0)});
    frames(0, 10);
    push(32'd350); chk("move_350", {22'h0, yof(y_a, 0)});
    key_a = 4'b1000; tick();
    push(32'h8); chk("hit_pulse", {28'h0, hit_a});
    push(32'h0); chk("hit_invalid", {16'h0, valid_a});
    push(32'd1); chk("hit_count1", {16'h0, cnt_a});
    for (int i = 0; i < 5; i++) begin
      tick();
      push(32'h0); chk("hold_no_hit", {28'h0, hit_a});
    end
    key_a = 0; tick();

    // Presses outside window, retire miss, simultaneous hit
    beat(0, 4'b0100);
    push(32'h0010); chk("lane1_valid", {16'h0, valid_a});
    frames(0, 139);
    key_a = 4'b0100; tick();
    push(32'h0); chk("early_press_hit", {28'h0, hit_a});
    push({28'h0, strict_miss}); chk("early_press_miss", {28'h0, miss_a});
    key_a = 0; tick();
    push(32'h0010); chk("early_press_keeps", {16'h0, valid_a});
    beat(0, 4'b0010);
    push(32'h0110); chk("lane2_valid", {16'h0, valid_a});
    frames(0, 300);
    key_a = 4'b0010; tick();
    push(32'h0); chk("edge300_no_hit", {28'h0, hit_a});
    push(32'h0110); chk("edge300_valid", {16'h0, valid_a});
    key_a = 0; tick();
    frames(0, 40);
    push(32'd479); chk("lane1_479", {22'h0, yof(y_a, 4)});
    push(32'd340); chk("lane2_340", {22'h0, yof(y_a, 8)});
    frame_a = 1; key_a = 4'b0010; tick(); frame_a = 0;
    push(32'h2); chk("combo_hit", {28'h0, hit_a});
    push(32'h4); chk("combo_miss", {28'h0, miss_a});
    push(32'h0); chk("combo_valid", {16'h0, valid_a});
    push(32'd2); chk("hit_count2", {16'h0, cnt_a});
    key_a = 0; tick();
    push(32'h0); chk("miss_one_cycle", {28'h0, miss_a});

    // Pool exhaustion
    for (int i = 0; i < 4; i++) begin
      beat(0, 4'b0001);
      push(32'h0); chk("fill_no_drop", {28'h0, drop_a});
    end
    push(32'hF000); chk("pool_full", {16'h0, valid_a});
    beat(0, 4'b0001);
    push(32'h1); chk("dropped", {28'h0, drop_a});
    push(32'hF000); chk("drop_valid", {16'h0, valid_a});
    tick();
    push(32'h0); chk("drop_one_cycle", {28'h0, drop_a});

    // Reset mid-song
    reset = 0; tick();
    push(32'h0); chk("midrst_valid", {16'h0, valid_a});
    push(32'h0); chk("midrst_busy", {31'h0, busy_a});
    push(32'h0); chk("midrst_pulses", {20'h0, hit_a, miss_a, drop_a});
    reset = 1; tick();
    push(32'h0); chk("midrst_idle", {29'h0, st_a});
    push(32'h0); chk("midrst_cnt", {16'h0, cnt_a});

    // Short song: drain and restart
    start_b = 1; tick(); start_b = 0;
    push(32'h1); chk("b_busy", {31'h0, busy_b});
    push(32'h0); chk("b_addr0", {26'h0, addr_b});
    beat(1, 4'b1000);
    push(32'd1); chk("b_addr1", {26'h0, addr_b});
    beat(1, 4'b0001);
    push(32'd4); chk("b_drain", {29'h0, st_b});
    push(32'h1001); chk("b_valid", {16'h0, valid_b});
    frames(1, 340);
    key_b = 4'b1000; tick();
    push(32'h8); chk("b_hit", {28'h0, hit_b});
    push(32'd1); chk("b_cnt1", {16'h0, cnt_b});
    key_b = 0; tick();
    frames(1, 139);
    push(32'd479); chk("b_y479", {22'h0, yof(y_b, 12)});
    frame_b = 1; tick(); frame_b = 0;
    push(32'h1); chk("b_miss", {28'h0, miss_b});
    push(32'h0); chk("b_empty", {16'h0, valid_b});
    tick();
    push(32'h1); chk("b_done", {31'h0, done_b});
    push(32'h0); chk("b_not_busy", {31'h0, busy_b});
    beat_b = 1; tick(); beat_b = 0;
    push(32'd5); chk("b_beat_ignored", {29'h0, st_b});
    start_b = 1; tick(); start_b = 0;
    push(32'h0); chk("b_restart_addr", {26'h0, addr_b});
    push(32'h0); chk("b_restart_cnt", {16'h0, cnt_b});
    push(32'h1); chk("b_restart_busy", {31'h0, busy_b});
    push(32'h0); chk("b_restart_done", {31'h0, done_b});

    // Final report
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: observed %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
